ptw_ad_update_ctrl: RTL and testbench

- Sequences the hardware Accessed/Dirty (A/D) update of an Sv32 PTE as a guarded read-modify-write on the data-memory port.
- The page-table walker hands over the leaf PTE address, the PTE value it used, and set-A/set-D requests.
- The block re-reads the PTE, checks it has not changed, sets A/D, writes it back, and reports one status.
- Sits between the PTW and the shared memory request port.

---
 rtl/ptw_ad_update_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_ptw_ad_update_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_ad_update_ctrl.sv
// Hardware Accessed/Dirty update sequencer for Sv32 leaf PTEs: guarded
// read-modify-write on the shared data-memory port with a single status response.
module ptw_ad_update_ctrl #(
  parameter logic        USE_HW_SET_AD  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned BIT_A          = 6,
  parameter int unsigned BIT_D          = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [33:0] req_paddr_i,
  input  logic [31:0] req_pte_i,
  input  logic        req_set_a_i,
  input  logic        req_set_d_i,
  output logic        rsp_valid_o,
  output logic [1:0]  rsp_status_o,
  output logic [31:0] rsp_pte_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [33:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int unsigned PA_W  = 34;
  localparam int unsigned PTE_W = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [PTE_W-1:0] A_MASK   = PTE_W'(1) << BIT_A;
  localparam logic [PTE_W-1:0] D_MASK   = PTE_W'(1) << BIT_D;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK_NOWRITE = 2'b00;
  localparam logic [1:0] ST_OK_WRITTEN = 2'b01;
  localparam logic [1:0] ST_RETRY      = 2'b10;
  localparam logic [1:0] ST_FAULT      = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [PA_W-1:0]   paddr_q, paddr_d;
  logic [PTE_W-1:0]  pte_q, pte_d;
  logic              set_a_q, set_a_d;
  logic              set_d_q, set_d_d;
  logic [PTE_W-1:0]  new_q, new_d;
  logic [1:0]        res_status_q, res_status_d;
  logic [PTE_W-1:0]  res_pte_q, res_pte_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic [PTE_W-1:0]  rsp_pte_q, rsp_pte_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [PA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [PTE_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic              need_c;
  logic              gnt_c;
  logic              timeout_c;
  logic              in_mem_state_c;
  logic [PTE_W-1:0]  new_c;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      paddr_q      <= '0;
      pte_q        <= '0;
      set_a_q      <= 1'b0;
      set_d_q      <= 1'b0;
      new_q        <= '0;
      res_status_q <= '0;
      res_pte_q    <= '0;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_pte_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      paddr_q      <= paddr_d;
      pte_q        <= pte_d;
      set_a_q      <= set_a_d;
      set_d_q      <= set_d_d;
      new_q        <= new_d;
      res_status_q <= res_status_d;
      res_pte_q    <= res_pte_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_pte_q    <= rsp_pte_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    paddr_d      = paddr_q;
    pte_d        = pte_q;
    set_a_d      = set_a_q;
    set_d_d      = set_d_q;
    new_d        = new_q;
    res_status_d = res_status_q;
    res_pte_d    = res_pte_q;
    cnt_d        = cnt_q;
    rsp_status_d = rsp_status_q;
    rsp_pte_d    = rsp_pte_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    need_c = (req_set_a_i && ((req_pte_i & A_MASK) == '0)) ||
             (req_set_d_i && ((req_pte_i & D_MASK) == '0));
    gnt_c     = mem_req_q && mem_gnt_i;
    timeout_c = (cnt_q == CNT_LAST);
    new_c     = mem_rdata_i | (set_a_q ? A_MASK : '0) | (set_d_q ? D_MASK : '0);

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i && ready_q) begin
          paddr_d = req_paddr_i;
          pte_d   = req_pte_i;
          set_a_d = req_set_a_i;
          set_d_d = req_set_d_i;
          if (!need_c) begin
            state_d      = S_RESP;
            res_status_d = ST_OK_NOWRITE;
            res_pte_d    = req_pte_i;
          end else if (!USE_HW_SET_AD) begin
            state_d      = S_RESP;
            res_status_d = ST_FAULT;
            res_pte_d    = req_pte_i;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (gnt_c) begin
          state_d = S_RD_WAIT;
        end else if (timeout_c) begin
          state_d      = S_RESP;
          res_status_d = ST_FAULT;
          res_pte_d    = pte_q;
        end
      end
      S_RD_WAIT: begin
        if (mem_rvalid_i) begin
          state_d = S_RESP;
          if (mem_err_i) begin
            res_status_d = ST_FAULT;
            res_pte_d    = pte_q;
          end else if (!mem_rdata_i[0]) begin
            res_status_d = ST_FAULT;
            res_pte_d    = mem_rdata_i;
          end else if (mem_rdata_i != pte_q) begin
            // PTE changed under us (another hart or SW); walker must restart
            res_status_d = ST_RETRY;
            res_pte_d    = mem_rdata_i;
          end else begin
            state_d = S_WR_REQ;
            new_d   = new_c;
          end
        end else if (timeout_c) begin
          state_d      = S_RESP;
          res_status_d = ST_FAULT;
          res_pte_d    = pte_q;
        end
      end
      S_WR_REQ: begin
        if (gnt_c) begin
          state_d = S_WR_WAIT;
        end else if (timeout_c) begin
          state_d      = S_RESP;
          res_status_d = ST_FAULT;
          res_pte_d    = pte_q;
        end
      end
      S_WR_WAIT: begin
        if (mem_rvalid_i) begin
          state_d      = S_RESP;
          res_status_d = mem_err_i ? ST_FAULT : ST_OK_WRITTEN;
          res_pte_d    = new_q;
        end else if (timeout_c) begin
          state_d      = S_RESP;
          res_status_d = ST_FAULT;
          res_pte_d    = pte_q;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_mem_state_c = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) ||
                     (state_q == S_WR_REQ) || (state_q == S_WR_WAIT);
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_mem_state_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Request stays up only while remaining in a REQ state, so it drops after grant or timeout
    mem_req_d = ((state_q == S_RD_REQ) && (state_d == S_RD_REQ)) ||
                ((state_q == S_WR_REQ) && (state_d == S_WR_REQ));
    mem_we_d  = (state_q == S_WR_REQ) && (state_d == S_WR_REQ);
    if (mem_req_d) begin
      mem_addr_d = paddr_q;
    end
    if (mem_we_d) begin
      mem_wdata_d = new_q;
    end

    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = (state_q == S_RESP);
    if (state_q == S_RESP) begin
      rsp_status_d = res_status_q;
      rsp_pte_d    = res_pte_q;
    end
  end

  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_status_o = rsp_status_q;
  assign rsp_pte_o    = rsp_pte_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_ptw_ad_update_ctrl.sv
// Scoreboard bench for ptw_ad_update_ctrl: directed requests against a simple
// memory responder; responses and write-backs are checked by separate monitors.
module tb_ptw_ad_update_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid2 = 1'b0;
  logic [33:0] req_paddr = '0;
  logic [31:0] req_pte = '0;
  logic        req_set_a = 1'b0;
  logic        req_set_d = 1'b0;

  logic        req_ready_o, rsp_valid_o, mem_req_o, mem_we_o;
  logic [1:0]  rsp_status_o;
  logic [31:0] rsp_pte_o, mem_wdata_o;
  logic [33:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;

  logic        ready2, rsp_valid2, mem_req2, mem_we2;
  logic [1:0]  status2;
  logic [31:0] pte2, wdata2;
  logic [33:0] addr2;
  logic        zero_bit = 1'b0;
  logic [31:0] zero_word = '0;

  ptw_ad_update_ctrl #(.USE_HW_SET_AD(1'b1), .TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_paddr_i(req_paddr), .req_pte_i(req_pte),
    .req_set_a_i(req_set_a), .req_set_d_i(req_set_d),
    .rsp_valid_o(rsp_valid_o), .rsp_status_o(rsp_status_o), .rsp_pte_o(rsp_pte_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  ptw_ad_update_ctrl #(.USE_HW_SET_AD(1'b0)) u_dut_nohw (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid2), .req_ready_o(ready2),
    .req_paddr_i(req_paddr), .req_pte_i(req_pte),
    .req_set_a_i(req_set_a), .req_set_d_i(req_set_d),
    .rsp_valid_o(rsp_valid2), .rsp_status_o(status2), .rsp_pte_o(pte2),
    .mem_req_o(mem_req2), .mem_we_o(mem_we2), .mem_addr_o(addr2),
    .mem_wdata_o(wdata2), .mem_gnt_i(zero_bit), .mem_rvalid_i(zero_bit),
    .mem_rdata_i(zero_word), .mem_err_i(zero_bit)
  );

  typedef struct {
    logic [1:0]  st;
    logic [31:0] pte;
    logic        chk_pte;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp2_q[$];
  logic [65:0] wr_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_cyc2 = 0;
  int n_req_cyc = 0;
  int n_req2 = 0;
  int n_grant = 0;
  int n_wr_grant = 0;
  int n_rsp = 0;

  logic [31:0] rd_data_cfg = '0;
  logic        rd_err_cfg = 1'b0;
  logic        wr_err_cfg = 1'b0;
  logic        gnt_en = 1'b1;
  int          rv_lat = 1;
  int          pend_cnt = 0;
  logic        pend_we = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void expect_rsp(input logic [1:0] st, input logic [31:0] p,
                                     input logic cp, input int lat);
    exp_q.push_back('{st, p, cp, lat});
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor for the main instance
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid_o) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: status %0d pte 0x%0h, none expected", rsp_status_o, rsp_pte_o);
      end else begin
        e = exp_q.pop_front();
        check("rsp_status", 64'(rsp_status_o), 64'(e.st));
        if (e.chk_pte) check("rsp_pte", 64'(rsp_pte_o), 64'(e.pte));
        if (e.lat > 0) check("rsp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
      end
    end
  end

  // Response monitor for the no-hardware-update instance
  always @(negedge clk) begin
    exp_t e;
    if (mem_req2) n_req2++;
    if (rsp_valid2) begin
      if (exp2_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp2: status %0d pte 0x%0h, none expected", status2, pte2);
      end else begin
        e = exp2_q.pop_front();
        check("rsp2_status", 64'(status2), 64'(e.st));
        check("rsp2_pte", 64'(pte2), 64'(e.pte));
        check("rsp2_latency", 64'(cyc - acc_cyc2), 64'(e.lat));
      end
    end
  end

  // Memory responder: grants while enabled, returns rvalid rv_lat cycles after grant
  always @(negedge clk) begin
    logic [65:0] w;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = '0;
    if (pend_cnt == 1) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = pend_we ? 32'h0 : rd_data_cfg;
      mem_err_i    = pend_we ? wr_err_cfg : rd_err_cfg;
    end
    if (pend_cnt > 0) pend_cnt--;
    mem_gnt_i = 1'b0;
    if (mem_req_o) n_req_cyc++;
    if (gnt_en && mem_req_o) begin
      mem_gnt_i = 1'b1;
      pend_cnt  = rv_lat;
      pend_we   = mem_we_o;
      n_grant++;
      if (mem_we_o) begin
        n_wr_grant++;
        if (wr_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", mem_addr_o, mem_wdata_o);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", 64'(mem_addr_o), 64'(w[65:32]));
          check("wr_data", 64'(mem_wdata_o), 64'(w[31:0]));
        end
      end
    end
  end

  task automatic send(input logic [33:0] a, input logic [31:0] p, input logic sa, input logic sd);
    int b;
    b = 0;
    @(negedge clk);
    while (!req_ready_o && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("req_ready", 64'(req_ready_o), 64'(1));
    req_paddr = a; req_pte = p; req_set_a = sa; req_set_d = sd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic send2(input logic [31:0] p, input logic sa, input logic sd);
    @(negedge clk);
    check("req_ready2", 64'(ready2), 64'(1));
    req_paddr = 34'h0_0000_1000; req_pte = p; req_set_a = sa; req_set_d = sd;
    req_valid2 = 1'b1;
    @(negedge clk);
    req_valid2 = 1'b0;
    acc_cyc2 = cyc;
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0 || wr_q.size() != 0) && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("drain_pending", 64'(exp_q.size() + exp2_q.size() + wr_q.size()), 64'(0));
    exp_q.delete();
    exp2_q.delete();
    wr_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int req0, wr0, rsp0, b;

    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check("rst_rsp_status", 64'(rsp_status_o), 64'(0));
    check("rst_rsp_pte", 64'(rsp_pte_o), 64'(0));
    check("rst_mem_req", 64'(mem_req_o), 64'(0));
    check("rst_mem_we", 64'(mem_we_o), 64'(0));
    check("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata_o), 64'(0));
    check("rst_req_ready", 64'(req_ready_o), 64'(1));
    rst_n = 1'b1;

    // A and D already set: no memory traffic
    req0 = n_req_cyc;
    expect_rsp(2'b00, 32'h0000_00C1, 1'b1, 1);
    send(34'h0_8000_0010, 32'h0000_00C1, 1'b1, 1'b1);
    wait_done();
    check("nowrite_traffic", 64'(n_req_cyc - req0), 64'(0));

    // Full update, both bits
    rd_data_cfg = 32'h0000_1001;
    wr_q.push_back({34'h0_8000_0010, 32'h0000_10C1});
    expect_rsp(2'b01, 32'h0000_10C1, 1'b1, 7);
    send(34'h0_8000_0010, 32'h0000_1001, 1'b1, 1'b1);
    wait_done();

    // PTE changed by another hart: RETRY, no write
    wr0 = n_wr_grant;
    rd_data_cfg = 32'h0000_1041;
    expect_rsp(2'b10, 32'h0000_1041, 1'b1, 4);
    send(34'h0_8000_0010, 32'h0000_1001, 1'b1, 1'b1);
    wait_done();
    check("retry_no_write", 64'(n_wr_grant - wr0), 64'(0));

    // Re-read shows V=0
    rd_data_cfg = 32'h0000_1000;
    expect_rsp(2'b11, 32'h0000_1000, 1'b1, 4);
    send(34'h0_8000_0010, 32'h0000_1001, 1'b1, 1'b1);
    wait_done();

    // Write acknowledged with bus error
    rd_data_cfg = 32'h0000_1001;
    wr_err_cfg  = 1'b1;
    wr_q.push_back({34'h0_8000_0010, 32'h0000_10C1});
    expect_rsp(2'b11, 32'h0000_10C1, 1'b1, 7);
    send(34'h0_8000_0010, 32'h0000_1001, 1'b1, 1'b1);
    wait_done();
    wr_err_cfg = 1'b0;

    // Set A only, high address bits in use
    rd_data_cfg = 32'h0000_0011;
    wr_q.push_back({34'h2_0000_1004, 32'h0000_0051});
    expect_rsp(2'b01, 32'h0000_0051, 1'b1, 7);
    send(34'h2_0000_1004, 32'h0000_0011, 1'b1, 1'b0);
    wait_done();

    // Set D only, A already present
    rd_data_cfg = 32'h0000_0041;
    wr_q.push_back({34'h0_0000_0FF0, 32'h0000_00C1});
    expect_rsp(2'b01, 32'h0000_00C1, 1'b1, 7);
    send(34'h0_0000_0FF0, 32'h0000_0041, 1'b0, 1'b1);
    wait_done();

    // Nothing requested
    req0 = n_req_cyc;
    expect_rsp(2'b00, 32'h0000_0001, 1'b1, 1);
    send(34'h0_0000_0100, 32'h0000_0001, 1'b0, 1'b0);
    wait_done();
    check("noreq_traffic", 64'(n_req_cyc - req0), 64'(0));

    // Grant never arrives: timeout after 4 cycles in RD_REQ
    gnt_en = 1'b0;
    expect_rsp(2'b11, 32'h0, 1'b0, 5);
    send(34'h0_8000_0010, 32'h0000_1001, 1'b1, 1'b1);
    wait_done();
    check("timeout_req_low", 64'(mem_req_o), 64'(0));
    check("timeout_idle_ready", 64'(req_ready_o), 64'(1));
    gnt_en = 1'b1;

    // Reset during WR_WAIT, write ack arrives late
    rv_lat = 4;
    rd_data_cfg = 32'h0000_1001;
    wr_q.push_back({34'h0_8000_0010, 32'h0000_10C1});
    wr0 = n_wr_grant;
    send(34'h0_8000_0010, 32'h0000_1001, 1'b1, 1'b1);
    b = 0;
    while (n_wr_grant == wr0 && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("reset_test_wr_grant", 64'(n_wr_grant - wr0), 64'(1));
    rsp0 = n_rsp;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("reset_no_rsp", 64'(n_rsp - rsp0), 64'(0));
    check("reset_mem_req", 64'(mem_req_o), 64'(0));
    check("reset_rsp_status", 64'(rsp_status_o), 64'(0));
    check("reset_rsp_pte", 64'(rsp_pte_o), 64'(0));
    check("reset_ready", 64'(req_ready_o), 64'(1));
    rv_lat = 1;

    // Normal operation after reset
    rd_data_cfg = 32'h00AB_C001;
    wr_q.push_back({34'h1_2345_6788, 32'h00AB_C041});
    expect_rsp(2'b01, 32'h00AB_C041, 1'b1, 7);
    send(34'h1_2345_6788, 32'h00AB_C001, 1'b1, 1'b0);
    wait_done();

    // Hardware A/D update disabled
    exp2_q.push_back('{2'b11, 32'h0000_0001, 1'b1, 1});
    send2(32'h0000_0001, 1'b1, 1'b0);
    wait_done();
    exp2_q.push_back('{2'b00, 32'h0000_0041, 1'b1, 1});
    send2(32'h0000_0041, 1'b1, 1'b0);
    wait_done();
    check("nohw_traffic", 64'(n_req2), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
